// File: rtl/spi_slave_pkg.sv
// Shared types and constants for the SPI slave responder.
package spi_slave_pkg;

  localparam int DATA_W_DEF     = 32;
  // sclk must be at least this many wb_clk_i cycles per period for the oversampler
  localparam int MIN_SCLK_RATIO = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE,
    WAIT_SS
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with a third delay flop for rise/fall detection.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      dly_q  <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
      dly_q  <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~dly_q;
  assign fall_o = ~sync_q & dly_q;

endmodule

// File: rtl/spi_slave_responder.sv
// Oversampling SPI slave: one TX holding buffer, a word shifter and RX strobe,
// with sticky underrun/overrun status cleared by rx_ack_i.
module spi_slave_responder
  import spi_slave_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SS_IDX = 0,
  parameter int LEN_W  = $clog2(DATA_W)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              sclk_pad_o,
  input  logic [7:0]        ss_pad_o,
  input  logic              mosi_pad_o,
  output logic              miso_pad_i,
  output logic              miso_oe_o,
  input  logic [LEN_W-1:0]  char_len_i,
  input  logic              lsb_i,
  input  logic              tx_neg_i,
  input  logic              rx_neg_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o,
  output logic              underrun_o,
  output logic              overrun_o,
  input  logic              rx_ack_i
);

  logic sclk_s, sclk_rise, sclk_fall;
  logic ss_s, ss_rise, ss_fall;
  logic mosi_meta, mosi_s;
  logic unused_sync;

  state_t            state_q;
  logic [LEN_W:0]    len_q;
  logic [LEN_W:0]    bitcnt_q;
  logic              sampled_q;
  logic [DATA_W-1:0] shreg_tx;
  logic [DATA_W-1:0] shreg_rx;
  logic [DATA_W-1:0] buf_q;
  logic              buf_full_q;
  logic              rx_pending_q;

  logic [LEN_W:0]    len_in;
  logic [LEN_W-1:0]  in_top_idx;
  logic [LEN_W-1:0]  top_idx;
  logic              sample_edge;
  logic              drive_edge;
  logic [LEN_W:0]    bitcnt_nxt;
  logic              do_drive;
  logic              take_buf;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] rx_mask;

  spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_n_i),
    .d      (sclk_pad_o),
    .sync_o (sclk_s),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // Select idles high, so resetting its synchroniser high avoids a false start
  spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_n_i),
    .d      (ss_pad_o[SS_IDX]),
    .sync_o (ss_s),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  assign unused_sync = sclk_s ^ ss_rise;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      mosi_meta <= mosi_pad_o;
      mosi_s    <= mosi_meta;
    end
  end

  assign len_in      = (char_len_i == '0) ? (LEN_W+1)'(DATA_W) : {1'b0, char_len_i};
  assign in_top_idx  = LEN_W'(len_in - (LEN_W+1)'(1));
  assign top_idx     = LEN_W'(len_q - (LEN_W+1)'(1));
  assign sample_edge = rx_neg_i ? sclk_fall : sclk_rise;
  assign drive_edge  = tx_neg_i ? sclk_fall : sclk_rise;
  assign bitcnt_nxt  = sample_edge ? (bitcnt_q - (LEN_W+1)'(1)) : bitcnt_q;
  // On a shared edge the sample is taken first, so drive sees the updated count
  assign do_drive    = drive_edge & (sampled_q | sample_edge) & (bitcnt_nxt != '0);
  assign tx_shift    = lsb_i ? (shreg_tx >> 1) : (shreg_tx << 1);
  assign rx_mask     = {DATA_W{1'b1}} >> (DATA_W - int'(len_q));
  assign take_buf    = (state_q == IDLE) & ss_fall & buf_full_q;
  assign tx_ready_o  = ~buf_full_q;

  always_comb begin
    rx_shift = '0;
    if (lsb_i) begin
      rx_shift          = shreg_rx >> 1;
      rx_shift[top_idx] = mosi_s;
    end else begin
      rx_shift = {shreg_rx[DATA_W-2:0], mosi_s};
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else if (take_buf) begin
      buf_full_q <= 1'b0;
    end else if (tx_valid_i && !buf_full_q) begin
      buf_q      <= tx_data_i;
      buf_full_q <= 1'b1;
    end
  end

  // Flag updates below the ack clear so a same-cycle completion or underrun wins
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q      <= IDLE;
      len_q        <= '0;
      bitcnt_q     <= '0;
      sampled_q    <= 1'b0;
      shreg_tx     <= '0;
      shreg_rx     <= '0;
      rx_pending_q <= 1'b0;
      miso_pad_i   <= 1'b0;
      miso_oe_o    <= 1'b0;
      rx_data_o    <= '0;
      rx_valid_o   <= 1'b0;
      busy_o       <= 1'b0;
      underrun_o   <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      rx_valid_o <= 1'b0;
      if (rx_ack_i) begin
        rx_pending_q <= 1'b0;
        underrun_o   <= 1'b0;
        overrun_o    <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          miso_pad_i <= 1'b0;
          miso_oe_o  <= 1'b0;
          busy_o     <= 1'b0;
          if (ss_fall) begin
            state_q   <= SHIFT;
            len_q     <= len_in;
            bitcnt_q  <= len_in;
            sampled_q <= 1'b0;
            shreg_rx  <= '0;
            miso_oe_o <= 1'b1;
            busy_o    <= 1'b1;
            if (buf_full_q) begin
              shreg_tx   <= buf_q;
              miso_pad_i <= lsb_i ? buf_q[0] : buf_q[in_top_idx];
            end else begin
              shreg_tx   <= '0;
              miso_pad_i <= 1'b0;
              underrun_o <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (ss_s) begin
            state_q    <= IDLE;
            busy_o     <= 1'b0;
            miso_oe_o  <= 1'b0;
            miso_pad_i <= 1'b0;
          end else begin
            if (sample_edge) begin
              shreg_rx  <= rx_shift;
              bitcnt_q  <= bitcnt_nxt;
              sampled_q <= 1'b1;
              if (bitcnt_nxt == '0) state_q <= DONE;
            end
            if (do_drive) begin
              shreg_tx   <= tx_shift;
              miso_pad_i <= lsb_i ? tx_shift[0] : tx_shift[top_idx];
            end
          end
        end
        DONE: begin
          rx_data_o    <= shreg_rx & rx_mask;
          rx_valid_o   <= 1'b1;
          rx_pending_q <= 1'b1;
          if (rx_pending_q) overrun_o <= 1'b1;
          busy_o       <= 1'b0;
          state_q      <= WAIT_SS;
        end
        WAIT_SS: begin
          if (ss_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Randomised scoreboard bench for spi_slave_responder driven by a bit-banged SPI master.
module tb_spi_slave_responder;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 5;
  localparam int H      = 5;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_n_i;
  logic              sclk_pad_o;
  logic [7:0]        ss_pad_o;
  logic              mosi_pad_o;
  logic              miso_pad_i;
  logic              miso_oe_o;
  logic [LEN_W-1:0]  char_len_i;
  logic              lsb_i;
  logic              tx_neg_i;
  logic              rx_neg_i;
  logic [DATA_W-1:0] tx_data_i;
  logic              tx_valid_i;
  logic              tx_ready_o;
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_valid_o;
  logic              busy_o;
  logic              underrun_o;
  logic              overrun_o;
  logic              rx_ack_i;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  logic        m_buf_full;
  logic [31:0] m_buf;
  logic        m_pending;
  logic        m_underrun;
  logic        m_overrun;
  logic [31:0] m_last_rx;

  spi_slave_responder #(.DATA_W(DATA_W), .SS_IDX(0)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_n_i (wb_rst_n_i),
    .sclk_pad_o (sclk_pad_o),
    .ss_pad_o   (ss_pad_o),
    .mosi_pad_o (mosi_pad_o),
    .miso_pad_i (miso_pad_i),
    .miso_oe_o  (miso_oe_o),
    .char_len_i (char_len_i),
    .lsb_i      (lsb_i),
    .tx_neg_i   (tx_neg_i),
    .rx_neg_i   (rx_neg_i),
    .tx_data_i  (tx_data_i),
    .tx_valid_i (tx_valid_i),
    .tx_ready_o (tx_ready_o),
    .rx_data_o  (rx_data_o),
    .rx_valid_o (rx_valid_o),
    .busy_o     (busy_o),
    .underrun_o (underrun_o),
    .overrun_o  (overrun_o),
    .rx_ack_i   (rx_ack_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  function automatic logic [31:0] len_mask(input int len);
    if (len >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << len) - 32'd1;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  // Monitor: every rx strobe must match the oldest outstanding completed transfer
  always @(negedge wb_clk_i) begin
    if (wb_rst_n_i && rx_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rx_valid: got strobe with 0x%08h, expected none", rx_data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("rx_strobe_data", rx_data_o, mon_exp);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    checkOutput({tag, "_miso"},     32'(miso_pad_i), 32'd0);
    checkOutput({tag, "_oe"},       32'(miso_oe_o),  32'd0);
    checkOutput({tag, "_ready"},    32'(tx_ready_o), 32'd1);
    checkOutput({tag, "_rx_data"},  rx_data_o,       32'd0);
    checkOutput({tag, "_rx_valid"}, 32'(rx_valid_o), 32'd0);
    checkOutput({tag, "_busy"},     32'(busy_o),     32'd0);
    checkOutput({tag, "_underrun"}, 32'(underrun_o), 32'd0);
    checkOutput({tag, "_overrun"},  32'(overrun_o),  32'd0);
  endtask

  task automatic model_reset();
    m_buf_full = 1'b0;
    m_buf      = '0;
    m_pending  = 1'b0;
    m_underrun = 1'b0;
    m_overrun  = 1'b0;
    m_last_rx  = '0;
  endtask

  task automatic load_tx(input logic [31:0] word);
    int waited;
    waited = 0;
    while (!tx_ready_o && waited < 50) begin
      cycles(1);
      waited++;
    end
    if (!tx_ready_o) begin
      checks++;
      errors++;
      $display("[TB] FAIL tx_ready_timeout: got ready=0 after 50 cycles, expected 1");
    end else begin
      tx_data_i  = word;
      tx_valid_i = 1'b1;
      cycles(1);
      tx_valid_i = 1'b0;
      m_buf_full = 1'b1;
      m_buf      = word;
      checkOutput("tx_ready_after_load", 32'(tx_ready_o), 32'd0);
    end
  endtask

  task automatic send_ack();
    rx_ack_i = 1'b1;
    cycles(1);
    rx_ack_i   = 1'b0;
    m_pending  = 1'b0;
    m_underrun = 1'b0;
    m_overrun  = 1'b0;
  endtask

  // Master side: mode_b=0 slave samples on rise / drives on fall, mode_b=1 the reverse
  task automatic applyStimulus(input int len, input bit lsb, input bit mode_b,
                               input logic [31:0] mosi_word, input int n_bits,
                               input bit raise, output logic [31:0] miso_word);
    int idx;
    char_len_i = LEN_W'(len % 32);
    lsb_i      = lsb;
    tx_neg_i   = ~mode_b;
    rx_neg_i   = mode_b;
    miso_word  = '0;
    ss_pad_o   = 8'hFE;
    cycles(H);
    for (int k = 0; k < n_bits; k++) begin
      idx = lsb ? k : (len - 1 - k);
      if (!mode_b) mosi_pad_o = mosi_word[idx];
      cycles(H);
      if (!mode_b) miso_word[idx] = miso_pad_i;
      sclk_pad_o = 1'b1;
      if (mode_b) mosi_pad_o = mosi_word[idx];
      cycles(H);
      if (mode_b) miso_word[idx] = miso_pad_i;
      sclk_pad_o = 1'b0;
    end
    cycles(H);
    if (raise) begin
      ss_pad_o   = 8'hFF;
      mosi_pad_o = 1'b0;
    end
  endtask

  task automatic do_xfer(input int len, input bit lsb, input bit mode_b,
                         input logic [31:0] mosi_word, input string tag);
    logic [31:0] got;
    logic [31:0] exp_miso;
    logic [31:0] m;
    m = len_mask(len);
    if (m_buf_full) begin
      exp_miso   = m_buf & m;
      m_buf_full = 1'b0;
    end else begin
      exp_miso   = '0;
      m_underrun = 1'b1;
    end
    if (m_pending) m_overrun = 1'b1;
    m_pending = 1'b1;
    m_last_rx = mosi_word & m;
    exp_q.push_back(mosi_word & m);
    applyStimulus(len, lsb, mode_b, mosi_word, len, 1'b1, got);
    cycles(8);
    checkOutput({tag, "_miso_word"}, got, exp_miso);
    checkOutput({tag, "_strobe_seen"}, 32'(exp_q.size()), 32'd0);
    checkOutput({tag, "_rx_data"}, rx_data_o, m_last_rx);
    checkOutput({tag, "_underrun"}, 32'(underrun_o), 32'(m_underrun));
    checkOutput({tag, "_overrun"}, 32'(overrun_o), 32'(m_overrun));
    checkOutput({tag, "_ready"}, 32'(tx_ready_o), 32'(!m_buf_full));
    checkOutput({tag, "_busy_idle"}, 32'(busy_o), 32'd0);
    checkOutput({tag, "_oe_idle"}, 32'(miso_oe_o), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [31:0] dummy;
    int          len;
    bit          lsb, mode_b;

    wb_rst_n_i = 1'b0;
    sclk_pad_o = 1'b0;
    ss_pad_o   = 8'hFF;
    mosi_pad_o = 1'b0;
    char_len_i = '0;
    lsb_i      = 1'b0;
    tx_neg_i   = 1'b1;
    rx_neg_i   = 1'b0;
    tx_data_i  = '0;
    tx_valid_i = 1'b0;
    rx_ack_i   = 1'b0;
    model_reset();
    cycles(3);
    check_reset_values("por");
    wb_rst_n_i = 1'b1;
    cycles(3);

    $display("[TB] mode 0 MSB-first byte");
    load_tx(32'h0000_00A5);
    do_xfer(8, 1'b0, 1'b0, 32'h0000_003C, "t1");
    send_ack();

    $display("[TB] LSB-first full word");
    load_tx(32'h1234_5678);
    do_xfer(32, 1'b1, 1'b1, 32'hDEAD_BEEF, "t2");
    send_ack();

    $display("[TB] underrun");
    do_xfer(16, 1'b0, 1'b0, 32'h0000_9A5C, "t3");
    send_ack();
    checkOutput("t3_underrun_cleared", 32'(underrun_o), 32'd0);

    $display("[TB] back-to-back overrun");
    load_tx(32'h0000_0011);
    do_xfer(8, 1'b0, 1'b0, 32'h0000_00C3, "t4a");
    load_tx(32'h0000_0022);
    do_xfer(8, 1'b0, 1'b0, 32'h0000_005A, "t4b");
    send_ack();
    checkOutput("t4_overrun_cleared", 32'(overrun_o), 32'd0);

    $display("[TB] abort after 5 edges");
    load_tx(32'h0000_00F0);
    m_buf_full = 1'b0;
    applyStimulus(8, 1'b0, 1'b0, 32'h0000_0077, 5, 1'b1, dummy);
    cycles(6);
    checkOutput("t5_busy_after_abort", 32'(busy_o), 32'd0);
    checkOutput("t5_ready_after_abort", 32'(tx_ready_o), 32'd1);
    load_tx(32'h0000_0096);
    do_xfer(8, 1'b0, 1'b0, 32'h0000_0069, "t5");
    send_ack();

    $display("[TB] reset mid-shift");
    load_tx(32'h0000_00B4);
    applyStimulus(8, 1'b0, 1'b0, 32'h0000_00E1, 3, 1'b0, dummy);
    checkOutput("t6_busy_mid_shift", 32'(busy_o), 32'd1);
    wb_rst_n_i = 1'b0;
    #1;
    check_reset_values("t6_async");
    ss_pad_o   = 8'hFF;
    mosi_pad_o = 1'b0;
    model_reset();
    cycles(3);
    wb_rst_n_i = 1'b1;
    cycles(4);
    load_tx(32'h0000_004D);
    do_xfer(8, 1'b0, 1'b0, 32'h0000_00D2, "t6");
    send_ack();

    $display("[TB] randomised transfers");
    for (int i = 0; i < 12; i++) begin
      len    = int'($urandom_range(1, 32));
      lsb    = bit'($urandom_range(0, 1));
      mode_b = bit'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) load_tx($urandom);
      do_xfer(len, lsb, mode_b, $urandom, "rnd");
      if ($urandom_range(0, 1) != 0) send_ack();
    end

    cycles(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
